// File: rtl/reorder_buffer_if.sv
// Issue, writeback, operand-query, commit and roll-back signals of the reorder buffer.
// slave is the reorder buffer itself; master is the surrounding core.
interface reorder_buffer_if #(
  parameter int ROB_ID_WIDTH = 4,
  parameter int DATA_WIDTH   = 32
);
  logic                    ID_issue_valid;
  logic [1:0]              ID_type;
  logic [4:0]              ID_rd;
  logic [DATA_WIDTH-1:0]   ID_pc;
  logic                    ID_pred_taken;
  logic                    ROB_full;
  logic [ROB_ID_WIDTH-1:0] ROB_rd_ROB_id;

  logic                    ALU_valid;
  logic [ROB_ID_WIDTH-1:0] ALU_ROB_id;
  logic [DATA_WIDTH-1:0]   ALU_value;
  logic                    ALU_taken;
  logic [DATA_WIDTH-1:0]   ALU_target_pc;
  logic                    LSB_valid;
  logic [ROB_ID_WIDTH-1:0] LSB_ROB_id;
  logic [DATA_WIDTH-1:0]   LSB_value;

  logic [ROB_ID_WIDTH-1:0] Q1_ROB_id;
  logic [ROB_ID_WIDTH-1:0] Q2_ROB_id;
  logic                    Q1_ready;
  logic                    Q2_ready;
  logic [DATA_WIDTH-1:0]   Q1_value;
  logic [DATA_WIDTH-1:0]   Q2_value;

  logic                    ROB_input_valid;
  logic [4:0]              ROB_rd;
  logic [DATA_WIDTH-1:0]   ROB_value;
  logic [ROB_ID_WIDTH-1:0] ROB_commit_ROB_id;
  logic                    ROB_store_commit_flag;
  logic [ROB_ID_WIDTH-1:0] ROB_store_ROB_id;
  logic                    ROB_roll_back_flag;
  logic [DATA_WIDTH-1:0]   ROB_roll_back_pc;

  modport master (
    output ID_issue_valid, ID_type, ID_rd, ID_pc, ID_pred_taken,
    output ALU_valid, ALU_ROB_id, ALU_value, ALU_taken, ALU_target_pc,
    output LSB_valid, LSB_ROB_id, LSB_value, Q1_ROB_id, Q2_ROB_id,
    input  ROB_full, ROB_rd_ROB_id, Q1_ready, Q2_ready, Q1_value, Q2_value,
    input  ROB_input_valid, ROB_rd, ROB_value, ROB_commit_ROB_id,
    input  ROB_store_commit_flag, ROB_store_ROB_id, ROB_roll_back_flag, ROB_roll_back_pc
  );

  modport slave (
    input  ID_issue_valid, ID_type, ID_rd, ID_pc, ID_pred_taken,
    input  ALU_valid, ALU_ROB_id, ALU_value, ALU_taken, ALU_target_pc,
    input  LSB_valid, LSB_ROB_id, LSB_value, Q1_ROB_id, Q2_ROB_id,
    output ROB_full, ROB_rd_ROB_id, Q1_ready, Q2_ready, Q1_value, Q2_value,
    output ROB_input_valid, ROB_rd, ROB_value, ROB_commit_ROB_id,
    output ROB_store_commit_flag, ROB_store_ROB_id, ROB_roll_back_flag, ROB_roll_back_pc
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order commit queue: allocates ids at issue, collects ALU/LSB results,
// retires one entry per cycle and flushes everything on a mispredicted branch.
module reorder_buffer #(
  parameter int ROB_SIZE     = 16,
  parameter int ROB_ID_WIDTH = 4,
  parameter int DATA_WIDTH   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  reorder_buffer_if.slave bus
);
  localparam logic [1:0] TYPE_STORE  = 2'b01;
  localparam logic [1:0] TYPE_BRANCH = 2'b10;

  logic [ROB_ID_WIDTH-1:0] head, tail;
  logic [ROB_ID_WIDTH:0]   count;
  logic [ROB_SIZE-1:0]     ent_valid, ent_ready;

  logic [1:0]              ent_type   [ROB_SIZE];
  logic [4:0]              ent_rd     [ROB_SIZE];
  logic [DATA_WIDTH-1:0]   ent_value  [ROB_SIZE];
  logic [DATA_WIDTH-1:0]   ent_pc     [ROB_SIZE];
  logic                    ent_pred   [ROB_SIZE];
  logic                    ent_taken  [ROB_SIZE];
  logic [DATA_WIDTH-1:0]   ent_target [ROB_SIZE];

  logic full, issue_en, alu_hit, lsb_hit, commit_en, mispredict;

  assign full      = (count == (ROB_ID_WIDTH+1)'(ROB_SIZE));
  assign issue_en  = bus.ID_issue_valid && !full && !bus.ROB_roll_back_flag;
  assign alu_hit   = bus.ALU_valid && !bus.ROB_roll_back_flag && ent_valid[bus.ALU_ROB_id];
  assign lsb_hit   = bus.LSB_valid && !bus.ROB_roll_back_flag && ent_valid[bus.LSB_ROB_id];
  assign commit_en = ent_valid[head] && ent_ready[head];
  assign mispredict = commit_en && (ent_type[head] == TYPE_BRANCH) &&
                      (ent_taken[head] != ent_pred[head]);

  assign bus.ROB_full      = full;
  assign bus.ROB_rd_ROB_id = tail;
  assign bus.Q1_ready      = ent_valid[bus.Q1_ROB_id] && ent_ready[bus.Q1_ROB_id];
  assign bus.Q2_ready      = ent_valid[bus.Q2_ROB_id] && ent_ready[bus.Q2_ROB_id];
  assign bus.Q1_value      = ent_value[bus.Q1_ROB_id];
  assign bus.Q2_value      = ent_value[bus.Q2_ROB_id];

  always_ff @(posedge clk) begin
    if (rst) begin
      head                      <= '0;
      tail                      <= '0;
      count                     <= '0;
      ent_valid                 <= '0;
      ent_ready                 <= '0;
      bus.ROB_input_valid       <= 1'b0;
      bus.ROB_rd                <= '0;
      bus.ROB_value             <= '0;
      bus.ROB_commit_ROB_id     <= '0;
      bus.ROB_store_commit_flag <= 1'b0;
      bus.ROB_store_ROB_id      <= '0;
      bus.ROB_roll_back_flag    <= 1'b0;
      bus.ROB_roll_back_pc      <= '0;
    end else if (!rdy) begin
      bus.ROB_input_valid       <= 1'b0;
      bus.ROB_store_commit_flag <= 1'b0;
      bus.ROB_roll_back_flag    <= 1'b0;
    end else begin
      bus.ROB_input_valid       <= 1'b0;
      bus.ROB_store_commit_flag <= 1'b0;
      bus.ROB_roll_back_flag    <= 1'b0;

      if (alu_hit) ent_ready[bus.ALU_ROB_id] <= 1'b1;
      if (lsb_hit) ent_ready[bus.LSB_ROB_id] <= 1'b1;

      if (issue_en) begin
        ent_valid[tail] <= 1'b1;
        ent_ready[tail] <= 1'b0;
        tail            <= tail + ROB_ID_WIDTH'(1);
      end

      if (commit_en) begin
        ent_valid[head] <= 1'b0;
        head            <= head + ROB_ID_WIDTH'(1);
        case (ent_type[head])
          TYPE_STORE: begin
            bus.ROB_store_commit_flag <= 1'b1;
            bus.ROB_store_ROB_id      <= head;
          end
          TYPE_BRANCH: begin
            if (mispredict) begin
              bus.ROB_roll_back_flag <= 1'b1;
              bus.ROB_roll_back_pc   <= ent_taken[head] ? ent_target[head]
                                                        : ent_pc[head] + DATA_WIDTH'(4);
            end
          end
          default: begin
            bus.ROB_input_valid   <= 1'b1;
            bus.ROB_rd            <= ent_rd[head];
            bus.ROB_value         <= ent_value[head];
            bus.ROB_commit_ROB_id <= head;
          end
        endcase
      end

      case ({issue_en, commit_en})
        2'b10:   count <= count + (ROB_ID_WIDTH+1)'(1);
        2'b01:   count <= count - (ROB_ID_WIDTH+1)'(1);
        default: count <= count;
      endcase

      // Flush overrides the issue/writeback/pop updates made above in the same edge.
      if (mispredict) begin
        ent_valid <= '0;
        ent_ready <= '0;
        head      <= '0;
        tail      <= '0;
        count     <= '0;
      end
    end
  end

  // Payload storage needs no reset: valid/ready gate every use of it.
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (issue_en) begin
        ent_type[tail] <= bus.ID_type;
        ent_rd[tail]   <= bus.ID_rd;
        ent_pc[tail]   <= bus.ID_pc;
        ent_pred[tail] <= bus.ID_pred_taken;
      end
      if (alu_hit) begin
        ent_value[bus.ALU_ROB_id]  <= bus.ALU_value;
        ent_taken[bus.ALU_ROB_id]  <= bus.ALU_taken;
        ent_target[bus.ALU_ROB_id] <= bus.ALU_target_pc;
      end
      if (lsb_hit) ent_value[bus.LSB_ROB_id] <= bus.LSB_value;
    end
  end
endmodule
